// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter that shares one Fibonacci LFSR among NREQ requesters.
// Define LFSR_RNG_STATS_EN to add the grant_count handshake counter output.
module lfsr_rng_arbiter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_INIT = '1,
    parameter int unsigned      NREQ      = 4,
    parameter int unsigned      STEPS     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    input  logic                     seed_valid,
    input  logic [WIDTH-1:0]         seed,
    output logic                     seed_ready,
    output logic [WIDTH-1:0]         lfsr_state
`ifdef LFSR_RNG_STATS_EN
   ,output logic [15:0]              grant_count
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;
    logic             rsp_hs;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by all-ones.
    function automatic logic [WIDTH-1:0] seed_guard(input logic [WIDTH-1:0] v);
        return (v == '0) ? '1 : v;
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Rotating-priority search starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign rsp_hs = rsp_valid_q & rsp_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (seed_valid) begin
                    lfsr_d = seed_guard(seed);
                end else if (win_found) begin
                    rsp_id_d       = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d          = 8'(STEPS - 1);
                    state_d        = ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = lfsr_step(lfsr_q);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    gnt_d       = '0;
                    rr_ptr_d    = next_ptr(rsp_id_q);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED_INIT;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef LFSR_RNG_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;

    // Free-running handshake count; wraps naturally at 16 bits.
    always_comb begin
        grant_count_d = grant_count_q;
        if (rsp_hs) begin
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`else
    // Statistics disabled: no counter is built.
`endif

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign seed_ready = (state_q == ST_IDLE);
    assign lfsr_state = lfsr_q;

endmodule
